// File: rtl/mul_shift_add_pkg.sv
// Shared definitions for the iterative RV32M multiply unit:
// opcode encodings and FSM state encoding.
package mul_shift_add_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NEG_A  = 3'd1;
    localparam logic [2:0] ST_NEG_B  = 3'd2;
    localparam logic [2:0] ST_ITER   = 3'd3;
    localparam logic [2:0] ST_FIX_LO = 3'd4;
    localparam logic [2:0] ST_FIX_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        NEG_A  = ST_NEG_A,
        NEG_B  = ST_NEG_B,
        ITER   = ST_ITER,
        FIX_LO = ST_FIX_LO,
        FIX_HI = ST_FIX_HI,
        DONE   = ST_DONE
    } mulState_e;

endpackage

// File: rtl/mul_shift_add_adder.sv
// Fixed-width 32-bit adder with carry in/out, shared by every arithmetic
// step of the multiply unit.
module adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, cin_i};

endmodule

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU. Signed operands are
// converted to magnitudes, multiplied over 32 cycles, then the product sign is restored.
module mul_shift_add
    import mul_shift_add_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    mulState_e       state_q, state_d;
    logic [1:0]      opReg_q, opReg_d;
    logic [XLEN-1:0] aReg_q, aReg_d;
    logic [XLEN-1:0] bReg_q, bReg_d;
    logic            signA_q, signA_d;
    logic            signB_q, signB_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] absA_q, absA_d;
    logic [XLEN-1:0] mult_q, mult_d;
    logic [XLEN-1:0] prod_q, prod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            carryK_q, carryK_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] addA, addB, addSum;
    logic            addCin, addCout;

    adder_32bit uAdder (
        .a_i    (addA),
        .b_i    (addB),
        .cin_i  (addCin),
        .sum_o  (addSum),
        .cout_o (addCout)
    );

    // Every negation is ~x + 1 through the shared adder, with carry-in as the +1.
    always_comb begin
        addA   = '0;
        addB   = '0;
        addCin = 1'b0;
        case (state_q)
            NEG_A: begin
                addA   = signA_q ? ~aReg_q : aReg_q;
                addCin = signA_q;
            end
            NEG_B: begin
                addA   = signB_q ? ~bReg_q : bReg_q;
                addCin = signB_q;
            end
            ITER: begin
                addA = prod_q;
                addB = mult_q[0] ? absA_q : '0;
            end
            FIX_LO: begin
                addA   = neg_q ? ~mult_q : mult_q;
                addCin = neg_q;
            end
            FIX_HI: begin
                addA   = neg_q ? ~prod_q : prod_q;
                addCin = neg_q & carryK_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opReg_d  = opReg_q;
        aReg_d   = aReg_q;
        bReg_d   = bReg_q;
        signA_d  = signA_q;
        signB_d  = signB_q;
        neg_d    = neg_q;
        absA_d   = absA_q;
        mult_d   = mult_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        carryK_d = carryK_q;
        result_d = result_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opReg_d = op;
                        aReg_d  = a;
                        bReg_d  = b;
                        signA_d = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && a[XLEN-1];
                        signB_d = (op == MUL_OP_MULH) && b[XLEN-1];
                        neg_d   = (((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && a[XLEN-1])
                                ^ ((op == MUL_OP_MULH) && b[XLEN-1]);
                        state_d = NEG_A;
                    end
                end
                NEG_A: begin
                    absA_d  = addSum;
                    state_d = NEG_B;
                end
                NEG_B: begin
                    mult_d  = addSum;
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
                ITER: begin
                    // The multiplier shifts out of mult as product low bits shift in.
                    prod_d = {addCout, addSum[XLEN-1:1]};
                    mult_d = {addSum[0], mult_q[XLEN-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = FIX_LO;
                    end
                end
                FIX_LO: begin
                    mult_d   = addSum;
                    carryK_d = addCout;
                    state_d  = FIX_HI;
                end
                FIX_HI: begin
                    prod_d   = addSum;
                    result_d = (opReg_q == MUL_OP_MUL) ? mult_q : addSum;
                    state_d  = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opReg_q  <= '0;
            aReg_q   <= '0;
            bReg_q   <= '0;
            signA_q  <= 1'b0;
            signB_q  <= 1'b0;
            neg_q    <= 1'b0;
            absA_q   <= '0;
            mult_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            carryK_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            opReg_q  <= opReg_d;
            aReg_q   <= aReg_d;
            bReg_q   <= bReg_d;
            signA_q  <= signA_d;
            signB_q  <= signB_d;
            neg_q    <= neg_d;
            absA_q   <= absA_d;
            mult_q   <= mult_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            carryK_q <= carryK_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add: a scoreboard queue holds reference
// products computed with 64-bit multiplication, compared when out_valid appears.
module tb_mul_shift_add;
    import mul_shift_add_pkg::*;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        kill;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    always #(PERIOD/2) clk = ~clk;

    mul_shift_add #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Reference: extend operands to 64 bits per op signedness and multiply mod 2^64.
    function automatic logic [31:0] model(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        logic [63:0] extA, extB, prod;
        extA = ((opIn == MUL_OP_MULH) || (opIn == MUL_OP_MULHSU)) ? {{32{aIn[31]}}, aIn} : {32'b0, aIn};
        extB = (opIn == MUL_OP_MULH) ? {{32{bIn[31]}}, bIn} : {32'b0, bIn};
        prod = extA * extB;
        return (opIn == MUL_OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                 output time tAcc, output bit ok);
        int waitCnt = 0;
        @(negedge clk);
        op       = opIn;
        a        = aIn;
        b        = bIn;
        in_valid = 1'b1;
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        ok = in_ready;
        if (!ok) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            tAcc = 0;
        end else begin
            @(posedge clk);
            tAcc = $time;
            expQ.push_back(model(opIn, aIn, bIn));
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic collect(input time tAcc, input int holdCycles, input string tag);
        int n = 0;
        int lat;
        logic [31:0] held;
        logic [31:0] exp;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
            void'(expQ.pop_front());
        end else begin
            lat = int'(($time - tAcc - PERIOD/2) / PERIOD);
            checkOutput({tag, "_latency"}, 64'(lat), 64'd36);
            held = result;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                checkOutput({tag, "_hold_result"}, 64'(result), 64'(held));
                checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                checkOutput({tag, "_hold_inready"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            exp = expQ.pop_front();
            checkOutput(tag, 64'(result), 64'(exp));
            @(posedge clk);
            #1 out_ready = 1'b0;
            checkOutput({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
            checkOutput({tag, "_idle"}, 64'(in_ready), 64'd1);
        end
    endtask

    task automatic runOne(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                          input string tag, input int holdCycles);
        time t;
        bit  ok;
        applyStimulus(opIn, aIn, bIn, t, ok);
        if (ok) collect(t, holdCycles, tag);
    endtask

    // Starts an op, aborts it with kill or rst during the 10th ITER cycle, and checks recovery.
    task automatic abortMidIter(input bit useReset, input string tag);
        time t;
        bit  ok;
        bit  seen = 1'b0;
        applyStimulus(MUL_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, t, ok);
        if (ok) begin
            void'(expQ.pop_back());
            repeat (11) @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_busy"}, 64'(in_ready), 64'd0);
            if (useReset) rst = 1'b1; else kill = 1'b1;
            @(posedge clk);
            #1;
            rst  = 1'b0;
            kill = 1'b0;
            checkOutput({tag, "_idle"}, 64'(in_ready), 64'd1);
            checkOutput({tag, "_no_valid"}, 64'(out_valid), 64'd0);
            if (useReset) checkOutput({tag, "_result_zero"}, 64'(result), 64'd0);
            repeat (40) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            checkOutput({tag, "_no_result"}, 64'(seen), 64'd0);
            runOne(MUL_OP_MULHU, 32'd3, 32'd5, {tag, "_mulhu_3x5"}, 0);
            runOne(MUL_OP_MUL,   32'd3, 32'd5, {tag, "_mul_3x5"}, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        kill      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        rst = 1'b0;

        runOne(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff_ff", 0);
        runOne(MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff_ff", 0);
        runOne(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min_min", 0);
        runOne(MUL_OP_MUL,    32'h8000_0000, 32'h8000_0000, "mul_min_min", 0);
        runOne(MUL_OP_MULH,   32'hFFFF_FFFF, 32'd7,         "mulh_m1_7", 0);
        runOne(MUL_OP_MUL,    32'hFFFF_FFFF, 32'd7,         "mul_m1_7", 0);
        runOne(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_ff", 0);
        runOne(MUL_OP_MULH,   32'h0000_0000, 32'h8000_0000, "mulh_negzero", 0);
        runOne(MUL_OP_MUL,    32'h0000_0000, 32'h8000_0000, "mul_negzero", 0);
        runOne(MUL_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, "mulhsu_min_ff", 0);
        runOne(MUL_OP_MULH,   32'h1234_5678, 32'hFEDC_BA98, "mulh_hold", 10);

        for (int i = 0; i < 12; i++) begin
            runOne(2'($urandom_range(0, 3)), $urandom, $urandom, "random", 0);
        end

        abortMidIter(1'b0, "kill");
        abortMidIter(1'b1, "rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
